// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests,
// buffers returned words in a 2-slot in-order queue and presents them to decode.
// Responses belonging to requests killed by a redirect are counted and dropped.
module fetch_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            err
);

  logic [XLEN-1:0]        r_pc_f;
  logic [1:0]             r_busy;
  logic [1:0]             r_filled;
  logic [1:0][XLEN-1:0]   r_pc;
  logic [1:0][XLEN-1:0]   r_instr;
  logic                   r_head;
  logic                   r_tail;
  logic [1:0]             r_drop_cnt;
  logic                   r_err;

  logic [1:0]             w_unf;
  logic [2:0]             w_busy_cnt;
  logic [2:0]             w_unf_cnt;
  logic                   w_fire;
  logic                   w_rsp_drop;
  logic                   w_rsp_fill;
  logic                   w_rsp_err;
  logic                   w_fill_idx;
  logic                   w_consume;
  logic [2:0]             w_redir_drop;

  assign w_unf      = r_busy & ~r_filled;
  assign w_busy_cnt = {2'b0, r_busy[0]} + {2'b0, r_busy[1]};
  assign w_unf_cnt  = {2'b0, w_unf[0]} + {2'b0, w_unf[1]};

  // Killed requests still in flight occupy issue credit just like busy slots.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          ((w_busy_cnt + {1'b0, r_drop_cnt}) < 3'd2);
  assign imem_req_addr  = r_pc_f;
  assign w_fire         = imem_req_valid && imem_req_ready;

  // Stale words are consumed by the drop counter before any slot is filled.
  assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != 2'd0);
  assign w_rsp_fill = imem_rsp_valid && (r_drop_cnt == 2'd0) && (|w_unf);
  assign w_rsp_err  = imem_rsp_valid && (r_drop_cnt == 2'd0) && !(|w_unf);
  // Queue is in order, so the head is the oldest busy slot.
  assign w_fill_idx = w_unf[r_head] ? r_head : ~r_head;

  assign valid_d   = rst_n && r_busy[r_head] && r_filled[r_head];
  assign instr_d   = valid_d ? r_instr[r_head] : NOP_INSTR;
  assign pc_d      = valid_d ? r_pc[r_head] : '0;
  assign pcplus4_d = pc_d + XLEN'(4);
  assign err       = r_err;
  assign w_consume = valid_d && !stall_d;

  // Requests still outstanding after this cycle's response, all of them now dead.
  assign w_redir_drop = w_unf_cnt - {2'b0, w_rsp_fill}
                      + {1'b0, r_drop_cnt} - {2'b0, w_rsp_drop};

  // Fetch PC, slot queue, drop counter and sticky error; redirect overrides all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_f     <= RESET_PC;
      r_busy     <= '0;
      r_filled   <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_drop_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_rsp_err) r_err <= 1'b1;
      if (w_rsp_fill) r_instr[w_fill_idx] <= imem_rsp_data;
      if (redirect_valid) begin
        r_busy     <= '0;
        r_filled   <= '0;
        r_head     <= 1'b0;
        r_tail     <= 1'b0;
        r_pc_f     <= redirect_pc;
        r_drop_cnt <= w_redir_drop[1:0];
      end else begin
        // Tail slot is guaranteed free when issuing; it never aliases head or fill.
        if (w_fire) begin
          r_busy[r_tail]   <= 1'b1;
          r_filled[r_tail] <= 1'b0;
          r_pc[r_tail]     <= r_pc_f;
          r_tail           <= ~r_tail;
          r_pc_f           <= r_pc_f + XLEN'(4);
        end
        if (w_rsp_fill) r_filled[w_fill_idx] <= 1'b1;
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 2'd1;
        if (w_consume) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= ~r_head;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected
// {pc, instr} pairs; a monitor pops and compares on every decode consume.
module tb_fetch_stage;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            stall_d;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            valid_d;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;
  logic            err;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .err(err)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } inf_t;

  exp_t exp_q[$];
  inf_t mem_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 1;
  int   acc   = 0;
  bit   inj   = 0;
  bit   mflush = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_pc(input logic [31:0] p);
    exp_t e;
    e.pc = p;
    e.instr = memw(p);
    exp_q.push_back(e);
  endtask

  task automatic wait_acc(input int t);
    int n;
    n = 0;
    while (acc < t && n < 200) begin step(); n++; end
    total++;
    if (acc < t) begin
      bad++;
      $display("FAIL wait_acc got=%0d want=%0d", acc, t);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 80) begin step(); n++; end
    repeat (3) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Memory: fixed latency, in order; can inject a spurious response or flush.
  initial begin
    inf_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      imem_rsp_valid = 1'b0;
      if (mflush) mem_q.delete();
      else if (inj) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memw(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + lat;
        mem_q.push_back(r);
        acc++;
      end
    end
  end

  // Monitor: every decode consume must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_d && !stall_d) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got pc=%h want none", pc_d);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", pc_d, e.pc);
          chk("sb_instr", instr_d, e.instr);
          chk("sb_pc4", pcplus4_d, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; imem_req_ready = 1'b0; stall_d = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_valid_d", 32'(valid_d), 32'd0);
    chk("rst_instr_d", instr_d, NOP);
    chk("rst_pc_d", pc_d, 32'd0);
    chk("rst_pcplus4", pcplus4_d, 32'd4);
    chk("rst_err", 32'(err), 32'd0);
    step();

    // Streaming, k=1, no stalls: first valid two cycles after release.
    rst_n = 1'b1; imem_req_ready = 1'b1; lat = 1;
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    @(negedge clk); chk("first_c0", 32'(valid_d), 32'd0);
    @(negedge clk); chk("first_c1", 32'(valid_d), 32'd0);
    @(negedge clk); chk("first_c2", 32'(valid_d), 32'd1);
    chk("first_pc", pc_d, 32'd0);
    wait_acc(8);
    imem_req_ready = 1'b0;
    drain();

    // Decode stall: both slots fill, issue stops, outputs frozen.
    stall_d = 1'b1; imem_req_ready = 1'b1;
    expect_pc(32'h20); expect_pc(32'h24);
    wait_acc(10);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge clk);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_valid", 32'(valid_d), 32'd1);
      chk("stall_pc", pc_d, 32'h20);
      chk("stall_instr", instr_d, memw(32'h20));
    end
    step();
    stall_d = 1'b0;
    drain();

    // k=3, two in flight, redirect to 0x100: both stale words dropped.
    lat = 3; imem_req_ready = 1'b1;
    expect_pc(32'h100); expect_pc(32'h104);
    wait_acc(12);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid_d", 32'(valid_d), 32'd0);
    chk("redir_drop2_block", 32'(imem_req_valid), 32'd0);
    wait_acc(14);
    imem_req_ready = 1'b0;
    drain();
    chk("redir_err", 32'(err), 32'd0);

    // Redirect coinciding with a response: only one killed request remains.
    lat = 2; imem_req_ready = 1'b1;
    expect_pc(32'h200); expect_pc(32'h204);
    wait_acc(16);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_rsp_issue", 32'(imem_req_valid), 32'd1);
    chk("redir_rsp_addr", imem_req_addr, 32'h200);
    wait_acc(18);
    imem_req_ready = 1'b0;
    drain();
    chk("redir_rsp_err", 32'(err), 32'd0);

    // Memory not ready: address holds, PC does not advance.
    lat = 1;
    expect_pc(32'h208);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      chk("nrdy_req_valid", 32'(imem_req_valid), 32'd1);
      chk("nrdy_addr", imem_req_addr, 32'h208);
      chk("nrdy_valid_d", 32'(valid_d), 32'd0);
    end
    step();
    imem_req_ready = 1'b1;
    wait_acc(19);
    imem_req_ready = 1'b0;
    drain();

    // Spurious response sets sticky err without producing an instruction.
    inj = 1'b1;
    step();
    inj = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("err_valid_d", 32'(valid_d), 32'd0);
    expect_pc(32'h20C);
    step();
    imem_req_ready = 1'b1;
    wait_acc(20);
    imem_req_ready = 1'b0;
    drain();
    chk("err_sticky", 32'(err), 32'd1);

    // Mid-stream reset with both slots held by a stall.
    stall_d = 1'b1; imem_req_ready = 1'b1;
    repeat (4) step();
    rst_n = 1'b0; mflush = 1'b1;
    step();
    mflush = 1'b0;
    @(negedge clk);
    chk("mrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mrst_valid_d", 32'(valid_d), 32'd0);
    chk("mrst_instr", instr_d, NOP);
    chk("mrst_pc", pc_d, 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    step();
    stall_d = 1'b0; imem_req_ready = 1'b0;
    step();
    rst_n = 1'b1;
    expect_pc(32'h0);
    base = acc;
    imem_req_ready = 1'b1;
    wait_acc(base + 1);
    imem_req_ready = 1'b0;
    drain();
    chk("final_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
